// File: rtl/bit_manip_unit.sv
// Bit manipulation unit: bit/byte reverse in one cycle, CLZ/CLO/popcount scanned STEP bits per cycle.
// Optional popcount (op 100) is built only when macro BIT_MANIP_POPCNT_EN is defined.
module bit_manip_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    localparam int unsigned NCHUNK = WIDTH / STEP;
    localparam int unsigned CNT_W  = $clog2(WIDTH) + 1;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [2:0] OP_BREV = 3'b000;
    localparam logic [2:0] OP_BYTE = 3'b001;
    localparam logic [2:0] OP_CLZ  = 3'b010;
    localparam logic [2:0] OP_CLO  = 3'b011;
`ifdef BIT_MANIP_POPCNT_EN
    localparam logic [2:0] OP_POP  = 3'b100;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_op,   w_op_nxt;
    logic [WIDTH-1:0]   r_data, w_data_nxt;
    logic [CNT_W-1:0]   r_cnt,  w_cnt_nxt;
    logic [IDX_W-1:0]   r_idx,  w_idx_nxt;
    logic [WIDTH-1:0]   r_dout, w_dout_nxt;
    logic               r_done, w_done_nxt;
    logic               r_busy, w_busy_nxt;

    logic               w_is_count;
    logic [WIDTH-1:0]   w_perm;
    logic [STEP-1:0]    w_top;
    logic [STEP-1:0]    w_scan;
    logic               w_last;
    logic [CNT_W-1:0]   w_sum;
    logic               w_term;

    function automatic logic [WIDTH-1:0] f_bitrev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            r[i] = v[int'(WIDTH) - 1 - i];
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] f_byterev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int j = 0; j < int'(WIDTH / 8); j++) begin
            r[8*j +: 8] = v[int'(WIDTH) - 8 - 8*j +: 8];
        end
        return r;
    endfunction

    // Leading zeros within one chunk; an all-zero chunk counts as STEP.
    function automatic logic [CNT_W-1:0] f_lz(input logic [STEP-1:0] v);
        logic [CNT_W-1:0] r;
        logic             found;
        r     = CNT_W'(STEP);
        found = 1'b0;
        for (int i = int'(STEP) - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                r     = CNT_W'(int'(STEP) - 1 - i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

`ifdef BIT_MANIP_POPCNT_EN
    function automatic logic [CNT_W-1:0] f_pop(input logic [STEP-1:0] v);
        logic [CNT_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(STEP); i++) begin
            r = r + CNT_W'(v[i]);
        end
        return r;
    endfunction
`endif

    // Decode of the incoming request: single-cycle permute result or multi-cycle scan.
    always_comb begin
        w_is_count = (op == OP_CLZ) || (op == OP_CLO);
`ifdef BIT_MANIP_POPCNT_EN
        if (op == OP_POP) begin
            w_is_count = 1'b1;
        end
`endif
        case (op)
            OP_BREV: w_perm = f_bitrev(din);
            OP_BYTE: w_perm = f_byterev(din);
            default: w_perm = din;
        endcase
    end

    // One chunk of the scan: CLO is CLZ of the inverted chunk.
    always_comb begin
        w_top  = r_data[WIDTH-1 -: STEP];
        w_last = (r_idx == IDX_W'(NCHUNK - 1));
        w_scan = (r_op == OP_CLO) ? ~w_top : w_top;
        w_sum  = r_cnt + f_lz(w_scan);
        w_term = (w_scan != '0) || w_last;
`ifdef BIT_MANIP_POPCNT_EN
        if (r_op == OP_POP) begin
            w_sum  = r_cnt + f_pop(w_top);
            w_term = w_last;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_data_nxt  = r_data;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_dout_nxt  = r_dout;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_op_nxt   = op;
                    w_data_nxt = din;
                    w_cnt_nxt  = '0;
                    w_idx_nxt  = '0;
                    if (w_is_count) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_dout_nxt  = w_perm;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (w_term) begin
                    w_state_nxt = S_DONE;
                    w_dout_nxt  = WIDTH'(w_sum);
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt  = w_sum;
                    w_data_nxt = r_data << STEP;
                    w_idx_nxt  = r_idx + IDX_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= '0;
            r_data <= '0;
            r_cnt  <= '0;
            r_idx  <= '0;
            r_dout <= '0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_op   <= w_op_nxt;
            r_data <= w_data_nxt;
            r_cnt  <= w_cnt_nxt;
            r_idx  <= w_idx_nxt;
            r_dout <= w_dout_nxt;
            r_done <= w_done_nxt;
            r_busy <= w_busy_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign dout = r_dout;

endmodule
